// File: rtl/acc_pkg.sv
// Shared types for the search-image memory and its window reader.
// Lane count, image geometry and request/response layouts live here.
package acc_pkg;

  localparam int SMEM_LANES = 8;
  localparam int SMEM_IMG_W = 31;
  localparam int SMEM_IMG_H = 31;
  localparam int SMEM_DEPTH = SMEM_IMG_W * SMEM_IMG_H;
  localparam int SMEM_AW    = $clog2(SMEM_DEPTH);

  typedef logic [SMEM_AW-1:0] smem_addr_t;

  typedef struct packed {
    logic                        write;
    smem_addr_t                  waddr;
    logic [7:0]                  wdata;
    smem_addr_t [SMEM_LANES-1:0] raddr;
  } smem_req_t;

  typedef struct packed {
    logic [SMEM_LANES-1:0][7:0] data;
  } smem_res_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_READ  = 2'd1,
    WR_DRAIN = 2'd2
  } wr_state_e;

endpackage

// File: rtl/smem_row_addr_gen.sv
// Combinational per-lane read addresses for one window row.
// With SMEM_RD_ZEROPAD_EN, lanes falling outside the image get address 0 and a pad flag.
module smem_row_addr_gen
  import acc_pkg::*;
#(
  parameter int IMG_W = SMEM_IMG_W,
  parameter int IMG_H = SMEM_IMG_H,
  parameter int WIN   = SMEM_LANES
) (
  input  logic [4:0]               org_x,
  input  logic [4:0]               org_y,
  input  logic [$clog2(WIN)-1:0]   row,
  output smem_addr_t [WIN-1:0]     raddr,
  output logic [WIN-1:0]           pad
);

  localparam smem_addr_t W_A = smem_addr_t'(IMG_W);

  logic [5:0] row_abs;
  assign row_abs = 6'(org_y) + 6'(row);

  for (genvar g = 0; g < WIN; g++) begin : g_lane
    logic [5:0] col_abs;
    logic       lane_pad;

    assign col_abs = 6'(org_x) + 6'(g);
`ifdef SMEM_RD_ZEROPAD_EN
    assign lane_pad = (int'(col_abs) >= IMG_W) || (int'(row_abs) >= IMG_H);
`else
    assign lane_pad = 1'b0;
`endif
    assign pad[g]   = lane_pad;
    assign raddr[g] = lane_pad ? '0 : smem_addr_t'(row_abs) * W_A + smem_addr_t'(col_abs);
  end

endmodule

// File: rtl/smem_window_reader.sv
// Fetches a WIN x WIN window from the search-image memory and streams it row by row.
// Optional SMEM_RD_ZEROPAD_EN accepts out-of-range origins and zero-fills pixels off the image.
module smem_window_reader
  import acc_pkg::*;
#(
  parameter int IMG_W = SMEM_IMG_W,
  parameter int IMG_H = SMEM_IMG_H,
  parameter int WIN   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [4:0]               org_x_i,
  input  logic [4:0]               org_y_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output smem_req_t                mem_req_o,
  input  smem_res_t                mem_res_i,
  output logic                     row_valid_o,
  input  logic                     row_ready_i,
  output logic [$clog2(WIN)-1:0]   row_idx_o,
  output logic                     row_last_o,
  output logic [WIN*8-1:0]         row_data_o
);

  localparam int RW = $clog2(WIN);

  if (WIN != SMEM_LANES) begin : g_win_check
    $error("smem_window_reader: WIN must equal SMEM_LANES");
  end

  wr_state_e            state_q, state_d;
  logic [4:0]           org_x_q, org_y_q;
  logic [RW-1:0]        row_cnt_q;
  logic                 row_valid_q, row_last_q, done_q, err_q;
  logic [RW-1:0]        row_idx_q;
  logic [WIN*8-1:0]     row_data_q;

  logic                 range_ok, start_ok, start_bad, cap, hs, done_d;
  smem_addr_t [WIN-1:0] gen_raddr;
  logic [WIN-1:0]       gen_pad;
  logic [WIN*8-1:0]     cap_data;

`ifdef SMEM_RD_ZEROPAD_EN
  assign range_ok = 1'b1;
`else
  assign range_ok = (int'(org_x_i) + WIN <= IMG_W) && (int'(org_y_i) + WIN <= IMG_H);
`endif

  smem_row_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN)
  ) u_addr_gen (
    .org_x (org_x_q),
    .org_y (org_y_q),
    .row   (row_cnt_q),
    .raddr (gen_raddr),
    .pad   (gen_pad)
  );

  for (genvar g = 0; g < WIN; g++) begin : g_cap
    assign cap_data[8*g +: 8] = gen_pad[g] ? 8'h00 : mem_res_i.data[g];
  end

  assign hs = row_valid_q & row_ready_i;

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    cap       = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (start_i) begin
          if (range_ok) begin
            start_ok = 1'b1;
            state_d  = WR_READ;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      WR_READ: begin
        // Capture whenever the output register is free or draining this cycle.
        cap = !row_valid_q || row_ready_i;
        if (cap && (row_cnt_q == RW'(WIN - 1))) state_d = WR_DRAIN;
      end
      WR_DRAIN: begin
        if (hs) begin
          state_d = WR_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WR_IDLE;
      org_x_q     <= '0;
      org_y_q     <= '0;
      row_cnt_q   <= '0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      row_idx_q   <= '0;
      row_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= start_bad;
      if (start_ok) begin
        org_x_q   <= org_x_i;
        org_y_q   <= org_y_i;
        row_cnt_q <= '0;
      end
      if (cap) begin
        row_data_q  <= cap_data;
        row_idx_q   <= row_cnt_q;
        row_last_q  <= (row_cnt_q == RW'(WIN - 1));
        row_cnt_q   <= row_cnt_q + 1'b1;
        row_valid_q <= 1'b1;
      end else if (hs) begin
        row_valid_q <= 1'b0;
      end
    end
  end

  // Addresses are only presented while fetching; the write side is never used.
  always_comb begin
    mem_req_o = '0;
    if (state_q == WR_READ) mem_req_o.raddr = gen_raddr;
  end

  assign busy_o      = (state_q != WR_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign row_valid_o = row_valid_q;
  assign row_idx_o   = row_idx_q;
  assign row_last_o  = row_last_q;
  assign row_data_o  = row_data_q;

endmodule

// File: doc/smem_window_reader.md
Name: smem_window_reader

Overview:
Read-side initiator for the search-image memory. On a start command it fetches a WIN x WIN window at a given (x, y) origin of the 31x31 search image, one row of WIN pixels per cycle, over the memory's parallel combinational read lanes. Rows are streamed to the matching/SAD datapath over a valid/ready interface. The block never writes the memory: write request fields are driven to zero.

Parameters:
IMG_W, 31, search image width in pixels
IMG_H, 31, search image height in pixels
WIN, 8, window side length; must equal the package read-lane count SMEM_LANES (elaboration-time assertion)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  start pulse; accepted only in IDLE
org_x_i  in  5  window origin column
org_y_i  in  5  window origin row
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse after the last row handshake
err_o  out  1  one-cycle pulse when a start is rejected for range
mem_req_o  out  smem_req_t  raddr[0..WIN-1] driven; write=0, waddr=0, wdata=0
mem_res_i  in  smem_res_t  data[0..WIN-1], combinational response to raddr
row_valid_o  out  1  output row valid
row_ready_i  in  1  consumer ready
row_idx_o  out  $clog2(WIN)  row index within the window of the current output row
row_last_o  out  1  high with row WIN-1
row_data_o  out  WIN*8  pixel i in bits [8i+7:8i]

Behaviour:
- Reset (async assert): FSM=IDLE; busy_o, done_o, err_o, row_valid_o, row_last_o = 0; row_idx_o = 0; row_data_o = 0; row counter = 0; raddr lanes = 0.
- FSM: IDLE -> READ on start_i with origin in range. IDLE -> IDLE with a 1-cycle err_o if org_x_i + WIN > IMG_W or org_y_i + WIN > IMG_H. READ -> DRAIN after row WIN-1 is captured. DRAIN -> IDLE on handshake of the last row; done_o pulses in the same cycle as that handshake is registered (the cycle after).
- Origin is latched at start. start_i is ignored while busy_o=1.
- Address of lane i, row r: (org_y + r)*IMG_W + org_x + i. Width is $clog2(IMG_W*IMG_H) (10 bits). Arithmetic is unsigned with no wrap, guaranteed by the range check.
- Read data is combinational. It is captured into the output register when the output is empty or is being consumed in the same cycle (row_valid_o & row_ready_i). The row counter advances only on capture.
- Latency: start accepted at edge 0; row 0 is valid after edge 1. Throughput is 1 row/cycle with row_ready_i held high, so all WIN rows arrive in WIN consecutive cycles.
- Backpressure: while row_valid_o & !row_ready_i, row_data_o, row_idx_o, row_last_o and raddr hold stable, and no capture occurs.
- Reset mid-window: immediate return to IDLE, output dropped, no done_o.

Optional Feature:
SMEM_RD_ZEROPAD_EN: when defined, out-of-range origins are accepted and err_o is tied 0. Any lane whose column is >= IMG_W, or row is >= IMG_H, drives raddr 0, and its pixel is replaced by 8'h00 at capture. When undefined, the range check and err_o behave as described in Behaviour.

Decomposition:
- acc_pkg holds: smem_req_t, smem_res_t, SMEM_LANES, SMEM_DEPTH, SMEM_AW, the IMG_W/IMG_H defaults, and the window-reader state enum.
- Sub-module smem_row_addr_gen: combinational lane address generation, plus the pad mask under SMEM_RD_ZEROPAD_EN. The FSM, counter and output register stay in the top module.

Test Plan:
- Memory preloaded with mem[a]=a[7:0]; start (0,0), ready=1 -> rows 0..7 on consecutive cycles; row 1 lane 0 = 8'h1F; row_last_o with row 7; done_o 1 cycle later.
- Start (23,23), ready=1 -> row 0 lane 0 address 736 (data 8'hE0); row 7 lane 7 address 960 (data 8'hC0); no err_o.
- Start (24,0) without the macro -> err_o pulse, busy_o stays 0, no row_valid_o. With SMEM_RD_ZEROPAD_EN -> lane 7 data 8'h00 on every row.
- Start (2,3) with ready toggled 1,0,0,1,... -> every row appears exactly once, in order, and stays stable while stalled; total rows = 8.
- start_i pulsed again mid-window -> ignored; origin unchanged. rst_i asserted after row 3 -> all outputs 0 asynchronously, no done_o; a fresh start then works normally.
- Checker: mem_req_o.write stays 0 throughout all tests.
